wb_regfile: RTL

//  Write-back end of the MEM->WB pipeline interface. Consumes the MEM2WB stage

---
 rtl/wb_regfile_pkg.sv | 8 +
 rtl/wb_read_port.sv | 17 +
 rtl/wb_result_mux.sv | 11 +
 rtl/wb_regfile.sv | 60 ++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and constants for the write-back register file
package wb_regfile_pkg;
  localparam int WIDTH = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int CNTW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_read_port.sv
// wb_read_port: one decode read port with $0 masking and write-first bypass
module wb_read_port
  import wb_regfile_pkg::*;
(
  input  logic             rst,
  input  logic             regwrite,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] stored,
  output logic [WIDTH-1:0] rd
);
  // bypass is gated by regwrite so a don't-care readdata never leaks out
  assign rd = (ra == REG_ZERO || !rst) ? '0
            : (regwrite && waddr == ra) ? wdata
            : stored;
endmodule

// File: rtl/wb_result_mux.sv
// wb_result_mux: memtoreg select between ALU result and load data
module wb_result_mux
  import wb_regfile_pkg::*;
(
  input  logic             memtoreg,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] result
);
  assign result = memtoreg ? readdata : aluout;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: WB result select, 32-entry GPR commit, bypassed read ports and debug/counter
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             regwrite_wb,
  input  logic             memtoreg_wb,
  input  logic [WIDTH-1:0] aluout_wb,
  input  logic [WIDTH-1:0] readdata_wb,
  input  logic [AW-1:0]    regaddr_wb,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] result_wb,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [CNTW-1:0]  wr_count
);
  logic [WIDTH-1:0] regs [1:NREG-1];
  logic [WIDTH-1:0] view [NREG];
  logic             commit;

  wb_result_mux u_mux (
    .memtoreg(memtoreg_wb),
    .aluout  (aluout_wb),
    .readdata(readdata_wb),
    .result  (result_wb)
  );

  assign commit = regwrite_wb && regaddr_wb != REG_ZERO;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[regaddr_wb] <= result_wb;
      wr_count <= wr_count + CNTW'(1);
    end

  // $0 has no storage; the view supplies a constant zero in its place
  assign view[0] = '0;
  for (genvar g = 1; g < NREG; g++) begin : g_view
    assign view[g] = regs[g];
  end

  wb_read_port u_rp1 (
    .rst(rst), .regwrite(regwrite_wb), .waddr(regaddr_wb), .wdata(result_wb),
    .ra(ra1), .stored(view[ra1]), .rd(rd1)
  );

  wb_read_port u_rp2 (
    .rst(rst), .regwrite(regwrite_wb), .waddr(regaddr_wb), .wdata(result_wb),
    .ra(ra2), .stored(view[ra2]), .rd(rd2)
  );

  assign dbg_data = rst ? view[dbg_addr] : '0;
endmodule
